tiny_alu_arbiter: RTL

Round-robin arbiter and sequencer that shares one `tiny_alu` instance between `NUM_REQ` requesters. It accepts one operation at a time over a valid/ready handshake, drives the ALU's `start`/operand/opcode inputs for exactly one cycle, and waits for the ALU's registered `done`. It then returns the result, tagged with the requester ID, over a valid/ready response channel. It sits between the requester ports and the ALU instance.

---
 rtl/tiny_alu_arbiter.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/tiny_alu_arbiter.sv
// tiny_alu_arbiter: round-robin front end that shares one tiny_alu between
// NUM_REQ requesters. One operation is in flight at a time:
// IDLE (grant) -> ISSUE (start pulse) -> WAIT (done) -> RESP (response).
// Optional feature macro: TINY_ALU_ARB_TIMEOUT_EN adds a WAIT watchdog that
// returns an error response after TIMEOUT_CYCLES cycles without done.

package tiny_alu_pkg;
  localparam int unsigned OPCODE_BITS = 3;

  localparam logic [OPCODE_BITS-1:0] NOP_OP = 3'd0;
  localparam logic [OPCODE_BITS-1:0] ADD_OP = 3'd1;
  localparam logic [OPCODE_BITS-1:0] SUB_OP = 3'd2;
  localparam logic [OPCODE_BITS-1:0] MUL_OP = 3'd3;
  localparam logic [OPCODE_BITS-1:0] AND_OP = 3'd4;
  localparam logic [OPCODE_BITS-1:0] OR_OP  = 3'd5;
  localparam logic [OPCODE_BITS-1:0] XOR_OP = 3'd6;
endpackage

module tiny_alu_arbiter
  import tiny_alu_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned INPUT_DATA_BITS = 8,
  parameter int unsigned ID_BITS         = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 15
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic [NUM_REQ-1:0]                   req_valid_i,
  output logic [NUM_REQ-1:0]                   req_ready_o,
  input  logic [NUM_REQ*INPUT_DATA_BITS-1:0]   req_a_i,
  input  logic [NUM_REQ*INPUT_DATA_BITS-1:0]   req_b_i,
  input  logic [NUM_REQ*OPCODE_BITS-1:0]       req_opcode_i,
  output logic                                 alu_start_o,
  output logic [INPUT_DATA_BITS-1:0]           alu_a_o,
  output logic [INPUT_DATA_BITS-1:0]           alu_b_o,
  output logic [OPCODE_BITS-1:0]               alu_opcode_o,
  input  logic                                 alu_done_i,
  input  logic [2*INPUT_DATA_BITS-1:0]         alu_result_i,
  output logic                                 rsp_valid_o,
  input  logic                                 rsp_ready_i,
  output logic [ID_BITS-1:0]                   rsp_id_o,
  output logic [2*INPUT_DATA_BITS-1:0]         rsp_result_o,
  output logic                                 rsp_err_o
);

  localparam int unsigned RES_BITS = 2 * INPUT_DATA_BITS;

  // Elaboration-time parameter sanity checks.
  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("tiny_alu_arbiter: NUM_REQ must be in 2..16");
  end
  if (ID_BITS < $clog2(NUM_REQ)) begin : g_bad_id_bits
    $error("tiny_alu_arbiter: ID_BITS too small for NUM_REQ");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("tiny_alu_arbiter: TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t state, state_next;

  logic [ID_BITS-1:0]         rr_ptr;
  logic [INPUT_DATA_BITS-1:0] cap_a;
  logic [INPUT_DATA_BITS-1:0] cap_b;
  logic [OPCODE_BITS-1:0]     cap_op;
  logic [ID_BITS-1:0]         cap_id;
  logic [RES_BITS-1:0]        result_q;
  logic                       wd_expired;

  logic [2*NUM_REQ-1:0]       valid_dbl;
  logic [NUM_REQ-1:0]         valid_rot;
  logic                       grant_found;
  logic [ID_BITS-1:0]         grant_idx;
  int unsigned                grant_sum;

  logic [INPUT_DATA_BITS-1:0] sel_a;
  logic [INPUT_DATA_BITS-1:0] sel_b;
  logic [OPCODE_BITS-1:0]     sel_op;
  logic [ID_BITS-1:0]         ptr_after;

  // Round-robin search: rotate valids so rr_ptr lands on bit 0, take the
  // first set bit, then rotate the index back into requester space.
  always_comb begin
    valid_dbl   = {req_valid_i, req_valid_i} >> rr_ptr;
    valid_rot   = valid_dbl[NUM_REQ-1:0];
    grant_found = 1'b0;
    grant_sum   = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && valid_rot[i]) begin
        grant_found = 1'b1;
        grant_sum   = 32'(rr_ptr) + i;
      end
    end
    if (grant_sum >= NUM_REQ) begin
      grant_sum = grant_sum - NUM_REQ;
    end
    grant_idx = ID_BITS'(grant_sum);
  end

  // Payload mux for the granted requester.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ID_BITS'(i) == grant_idx) begin
        sel_a  = req_a_i[i*INPUT_DATA_BITS +: INPUT_DATA_BITS];
        sel_b  = req_b_i[i*INPUT_DATA_BITS +: INPUT_DATA_BITS];
        sel_op = req_opcode_i[i*OPCODE_BITS +: OPCODE_BITS];
      end
    end
  end

  // Ready is offered only in IDLE and only to the granted requester.
  always_comb begin
    req_ready_o = '0;
    if (state == ST_IDLE && grant_found) begin
      req_ready_o = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx;
    end
  end

  // Pointer moves to the requester just after the one that was served.
  always_comb begin
    ptr_after = cap_id + 1'b1;
    if (cap_id == ID_BITS'(NUM_REQ - 1)) begin
      ptr_after = '0;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; done wins over a simultaneous watchdog expiry.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (grant_found) state_next = ST_ISSUE;
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  if (alu_done_i || wd_expired) state_next = ST_RESP;
      ST_RESP:  if (rsp_ready_i) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Capture request payload, ALU result and advance the round-robin pointer.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cap_a    <= '0;
      cap_b    <= '0;
      cap_op   <= '0;
      cap_id   <= '0;
      result_q <= '0;
      rr_ptr   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_found) begin
            cap_a  <= sel_a;
            cap_b  <= sel_b;
            cap_op <= sel_op;
            cap_id <= grant_idx;
          end
        end
        ST_WAIT: begin
          if (alu_done_i) begin
            result_q <= alu_result_i;
          end else if (wd_expired) begin
            result_q <= '0;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rr_ptr <= ptr_after;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TINY_ALU_ARB_TIMEOUT_EN
  logic [7:0] wd_cnt;
  logic       err_q;

  assign wd_expired = (state == ST_WAIT) && (wd_cnt == 8'(TIMEOUT_CYCLES - 1));

  // Watchdog counts WAIT cycles; err reflects how the last WAIT ended.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        ST_ISSUE: wd_cnt <= '0;
        ST_WAIT: begin
          wd_cnt <= wd_cnt + 8'd1;
          if (alu_done_i) begin
            err_q <= 1'b0;
          end else if (wd_expired) begin
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_err_o = err_q;
`else
  assign wd_expired = 1'b0;
  assign rsp_err_o  = 1'b0;
`endif

  assign alu_start_o  = (state == ST_ISSUE);
  assign alu_a_o      = cap_a;
  assign alu_b_o      = cap_b;
  assign alu_opcode_o = cap_op;
  assign rsp_valid_o  = (state == ST_RESP);
  assign rsp_id_o     = cap_id;
  assign rsp_result_o = result_q;

endmodule
